// File: rtl/dict_loader_pkg.sv
// dict_loader_pkg: loader states, header field layout and default image base.
// CHK exists only when DICT_LOADER_CHECKSUM_EN is defined.
package dict_loader_pkg;
  localparam int CNT_W = 10;
  localparam int CNT1_OFF = 0;
  localparam int CNT2_OFF = 10;
  localparam int CNT3_OFF = 20;
  localparam logic [31:0] IMAGE_BASE_DEFAULT = 32'h0000_F000;
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD1,
    LOAD2,
    LOAD3,
`ifdef DICT_LOADER_CHECKSUM_EN
    CHK,
`endif
    FIN
  } state_e;
endpackage

// File: rtl/dict_loader.sv
// dict_loader: boot-time loader that fills dict1/2/3 from a memory image at IMAGE_BASE.
// Define DICT_LOADER_CHECKSUM_EN to read and verify a trailing XOR checksum word.
module dict_loader
  import dict_loader_pkg::*;
#(
  parameter int FIELD1_KEY_WIDTH = 3,
  parameter int FIELD2_KEY_WIDTH = 5,
  parameter int FIELD3_KEY_WIDTH = 8,
  parameter int FIELD1_VAL_WIDTH = 7,
  parameter int FIELD2_VAL_WIDTH = 10,
  parameter int FIELD3_VAL_WIDTH = 15,
  parameter logic [31:0] IMAGE_BASE = IMAGE_BASE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic                        dict2_write_enable,
  output logic                        dict3_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);
  state_e state_q, state_d, after_hdr, after_l1, after_l2, after_l3;
  logic [CNT_W-1:0] cnt_q, cnt_d, c1, c2, c3;
  logic [3*CNT_W-1:0] hdr_q, hdr_w;
  logic [31:0] addr_q, cap_q;
  logic valid_q, error_q, error_d, acc, ovf;
  logic [2:0] we_q;
  logic unused_cap;
  assign acc = valid_q & mem_req_ready;
  // counts come straight from the bus while the header is being accepted
  assign hdr_w = state_q == HDR ? mem_req_rdata[3*CNT_W-1:0] : hdr_q;
  assign c1 = hdr_w[CNT1_OFF +: CNT_W];
  assign c2 = hdr_w[CNT2_OFF +: CNT_W];
  assign c3 = hdr_w[CNT3_OFF +: CNT_W];
  assign ovf = 32'(c1) > (32'd1 << FIELD1_KEY_WIDTH) ||
               32'(c2) > (32'd1 << FIELD2_KEY_WIDTH) ||
               32'(c3) > (32'd1 << FIELD3_KEY_WIDTH);
`ifdef DICT_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  assign after_l3 = CHK;
`else
  assign after_l3 = FIN;
`endif
  assign after_l2 = c3 != '0 ? LOAD3 : after_l3;
  assign after_l1 = c2 != '0 ? LOAD2 : after_l2;
  assign after_hdr = c1 != '0 ? LOAD1 : after_l1;
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HDR;
        error_d = 1'b0;
      end
      HDR: if (acc) begin
        state_d = ovf ? FIN : after_hdr;
        error_d = ovf;
      end
      LOAD1: if (acc && cnt_q == CNT_W'(1)) state_d = after_l1;
      LOAD2: if (acc && cnt_q == CNT_W'(1)) state_d = after_l2;
      LOAD3: if (acc && cnt_q == CNT_W'(1)) state_d = after_l3;
`ifdef DICT_LOADER_CHECKSUM_EN
      CHK: if (acc) begin
        state_d = FIN;
        error_d = mem_req_rdata != sum_q;
      end
`endif
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? (state_d == LOAD1 ? c1 : state_d == LOAD2 ? c2 : c3)
                               : cnt_q - CNT_W'(acc);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hdr_q <= '0;
      addr_q <= '0;
      cap_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      we_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      error_q <= error_d;
      valid_q <= busy && !acc;
      we_q <= {acc && state_q == LOAD3, acc && state_q == LOAD2, acc && state_q == LOAD1};
      if (state_q == IDLE && start) addr_q <= IMAGE_BASE;
      else if (acc) addr_q <= addr_q + 32'd4;
      if (acc) cap_q <= mem_req_rdata;
      if (acc && state_q == HDR) hdr_q <= mem_req_rdata[3*CNT_W-1:0];
    end
`ifdef DICT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sum_q <= '0;
    else if (state_q == IDLE) sum_q <= '0;
    else if (acc && state_q inside {LOAD1, LOAD2, LOAD3}) sum_q <= sum_q ^ mem_req_rdata;
`endif
  assign busy = state_q != IDLE && state_q != FIN;
  assign done = state_q == FIN;
  assign error = error_q;
  assign mem_req_valid = valid_q;
  assign mem_req_addr = addr_q;
  assign {dict3_write_enable, dict2_write_enable, dict1_write_enable} = we_q;
  assign dict1_write_val = cap_q[FIELD1_VAL_WIDTH-1:0];
  assign dict2_write_val = cap_q[FIELD2_VAL_WIDTH-1:0];
  assign dict3_write_val = cap_q[FIELD3_VAL_WIDTH-1:0];
  assign unused_cap = ^cap_q;
endmodule

// File: tb/tb_dict_loader.sv
// tb_dict_loader: randomized self-checking bench for dict_loader against a queue-based image model.
`timescale 1ns/1ps
module tb_dict_loader;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, mem_req_ready = 1'b0;
  logic [31:0] mem_req_rdata = '0;
  logic busy, done, error, mem_req_valid, we1, we2, we3;
  logic [31:0] mem_req_addr;
  logic [6:0] v1;
  logic [9:0] v2;
  logic [14:0] v3;

  always #5 clk = ~clk;

  dict_loader dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .error(error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rdata(mem_req_rdata), .dict1_write_enable(we1), .dict2_write_enable(we2),
    .dict3_write_enable(we3), .dict1_write_val(v1), .dict2_write_val(v2), .dict3_write_val(v3)
  );

  int vectors = 0, miscompares = 0;
  logic [31:0] mem [int];
  logic [31:0] ent [$];
  logic [31:0] rd_q [$];
  int wr_d [$];
  logic [31:0] wr_v [$];
  int wait_cnt = 0, stall = 0, unstable = 0, multi = 0, late = 0;
  logic [31:0] hold_addr = '0;
  bit prev_acc = 0;

  // memory responder and write monitor, both on the falling edge
  always @(negedge clk) begin
    int nw, idx;
    nw = int'(we1) + int'(we2) + int'(we3);
    if (nw > 1) multi++;
    if (nw > 0 && !prev_acc) late++;
    if (we1) begin wr_d.push_back(1); wr_v.push_back(32'(v1)); end
    if (we2) begin wr_d.push_back(2); wr_v.push_back(32'(v2)); end
    if (we3) begin wr_d.push_back(3); wr_v.push_back(32'(v3)); end
    prev_acc = 0;
    if (!resetn || !mem_req_valid) begin
      mem_req_ready = 1'b0;
      mem_req_rdata = $urandom;
      wait_cnt = 0;
    end else begin
      if (wait_cnt == 0) hold_addr = mem_req_addr;
      else if (mem_req_addr != hold_addr) unstable++;
      if (wait_cnt >= stall) begin
        idx = int'((mem_req_addr - 32'hF000) >> 2);
        mem_req_ready = 1'b1;
        mem_req_rdata = mem.exists(idx) ? mem[idx] : 32'hDEAD_BEEF;
        rd_q.push_back(mem_req_addr);
        prev_acc = 1;
      end else begin
        mem_req_ready = 1'b0;
        mem_req_rdata = $urandom;
        wait_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] hdr(input int a, input int b, input int c, input logic [1:0] top);
    return {top, 10'(c), 10'(b), 10'(a)};
  endfunction

  task automatic gen(input int n);
    ent.delete();
    repeat (n) ent.push_back($urandom);
  endtask

  task automatic run(input logic [31:0] h, input int stl, input bit dbl, input logic [31:0] flip,
                     input string tag);
    int n1, n2, n3, nrd, lat;
    bit ovf, seen, exp_err, err_at_done, busy_at_done;
    logic [31:0] xr;
    int ed [$];
    logic [31:0] ev [$];
    n1 = int'(h[9:0]);
    n2 = int'(h[19:10]);
    n3 = int'(h[29:20]);
    ovf = n1 > 8 || n2 > 32 || n3 > 256;
    mem.delete();
    mem[0] = h;
    xr = '0;
    foreach (ent[i]) begin
      mem[i + 1] = ent[i];
      xr ^= ent[i];
    end
    nrd = ovf ? 1 : 1 + n1 + n2 + n3;
    exp_err = ovf;
`ifdef DICT_LOADER_CHECKSUM_EN
    mem[ent.size() + 1] = xr ^ flip;
    if (!ovf) begin
      nrd++;
      exp_err = flip != 0;
    end
`else
    if (flip != 0) xr = '0;
`endif
    if (!ovf)
      foreach (ent[i]) begin
        ed.push_back(i < n1 ? 1 : i < n1 + n2 ? 2 : 3);
        ev.push_back(i < n1 ? ent[i] & 32'h7F : i < n1 + n2 ? ent[i] & 32'h3FF : ent[i] & 32'h7FFF);
      end
    stall = stl;
    rd_q.delete(); wr_d.delete(); wr_v.delete();
    unstable = 0; multi = 0; late = 0;
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    seen = 0;
    while (!seen && lat < 5000) begin
      @(posedge clk);
      lat++;
      #1 if (lat >= (dbl ? 2 : 1)) start = 1'b0;
      @(negedge clk);
      seen = done;
      err_at_done = error;
      busy_at_done = busy;
    end
    start = 1'b0;
    chk({tag, "/done_seen"}, 128'(seen), 128'(1));
    chk({tag, "/latency"}, 128'(lat), 128'(nrd * (2 + stl) + 1));
    chk({tag, "/error"}, 128'(err_at_done), 128'(exp_err));
    chk({tag, "/busy_at_done"}, 128'(busy_at_done), 128'(0));
    @(negedge clk);
    chk({tag, "/done_pulse"}, 128'({done, busy}), 128'(0));
    chk({tag, "/error_sticky"}, 128'(error), 128'(exp_err));
    chk({tag, "/reads"}, 128'(rd_q.size()), 128'(nrd));
    for (int i = 0; i < rd_q.size() && i < nrd; i++)
      chk({tag, "/rd_addr"}, 128'(rd_q[i]), 128'(32'hF000 + 32'(4 * i)));
    chk({tag, "/writes"}, 128'(wr_d.size()), 128'(ed.size()));
    for (int i = 0; i < wr_d.size() && i < ed.size(); i++)
      chk({tag, "/wr"}, {64'(wr_d[i]), 64'(wr_v[i])}, {64'(ed[i]), 64'(ev[i])});
    chk({tag, "/addr_stable"}, 128'(unstable), 128'(0));
    chk({tag, "/one_dict"}, 128'(multi), 128'(0));
    chk({tag, "/wr_timing"}, 128'(late), 128'(0));
  endtask

  initial begin
    int a, b, c, k;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_error", 128'(error), 128'(0));
    chk("rst_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_addr", 128'(mem_req_addr), 128'(0));
    chk("rst_we", 128'({we1, we2, we3}), 128'(0));
    chk("rst_vals", 128'({v1, v2, v3}), 128'(0));
    resetn = 1'b1;
    @(negedge clk);
    gen(6);  run(hdr(2, 1, 3, 2'b00), 0, 0, 0, "spec");
    ent.delete(); run(hdr(9, 0, 0, 2'b11), 0, 0, 0, "ovf1");
    ent.delete(); run(hdr(0, 0, 0, 2'b10), 0, 1, 0, "zero");
    gen(6);  run(hdr(2, 1, 3, 2'b01), 5, 0, 0, "stall5");
    gen(40); run(hdr(8, 32, 0, 2'b00), 0, 1, 0, "bound");
    ent.delete(); run(hdr(1, 33, 2, 2'b00), 1, 0, 0, "ovf2");
    ent.delete(); run(hdr(0, 0, 257, 2'b00), 0, 0, 0, "ovf3");
    for (int r = 0; r < 10; r++) begin
      a = $urandom_range(0, 8);
      b = $urandom_range(0, 6);
      c = $urandom_range(0, 6);
      if ($urandom_range(0, 5) == 0) a = $urandom_range(9, 1023);
      if (a > 8) ent.delete(); else gen(a + b + c);
      run(hdr(a, b, c, 2'($urandom)), $urandom_range(0, 3), 1'($urandom), 0, "rand");
    end
    gen(6);
    mem.delete();
    mem[0] = hdr(2, 1, 3, 2'b00);
    foreach (ent[i]) mem[i + 1] = ent[i];
    stall = 1;
    wr_d.delete(); wr_v.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (wr_d.size() < 3 && k < 200) begin
      @(negedge clk);
      #1 k++;
    end
    chk("rst_mid_reach3", 128'(wr_d.size()), 128'(3));
    resetn = 1'b0;
    #1;
    chk("rst_mid_outs", {busy, done, error, mem_req_valid, mem_req_addr, we1, we2, we3, v1, v2, v3}, 128'(0));
    repeat (3) @(negedge clk);
    chk("rst_mid_nowr", 128'(wr_d.size()), 128'(3));
    resetn = 1'b1;
    gen(6); run(hdr(2, 1, 3, 2'b00), 0, 0, 0, "after_rst");
`ifdef DICT_LOADER_CHECKSUM_EN
    ent.delete(); ent.push_back(32'h11); ent.push_back(32'h22);
    run(hdr(2, 0, 0, 2'b00), 0, 0, 32'h0, "csum_ok");
    run(hdr(2, 0, 0, 2'b00), 0, 0, 32'h7, "csum_bad");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dict_loader.md
# dict_loader

Boot-time loader that fills the three compression dictionaries from a memory-resident image before instruction fetch begins. It sits directly upstream of the compressed-fetch controller and drives that controller's dict1/dict2/dict3 write ports. It fetches a header word and then the entry words over the same valid/ready word-read protocol the controller uses. While it runs, `busy` is high so that the top level can hold off `proc_valid`.

## Interface
- FIELD1_KEY_WIDTH, 3, dict1 key width; dict1 capacity is 2^3 entries
- FIELD2_KEY_WIDTH, 5, dict2 key width
- FIELD3_KEY_WIDTH, 8, dict3 key width
- FIELD1_VAL_WIDTH, 7, dict1 value width
- FIELD2_VAL_WIDTH, 10, dict2 value width
- FIELD3_VAL_WIDTH, 15, dict3 value width
- IMAGE_BASE, 32'h0000_F000, byte address of the header word

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load
- busy  out  1  high from the cycle after an accepted start until `done`
- done  out  1  one-cycle pulse when a load ends, whether it succeeded or failed
- error  out  1  sticky failure flag; cleared by the next accepted start
- mem_req_valid  out  1  word read request
- mem_req_ready  in  1  `mem_req_rdata` is valid in this cycle
- mem_req_addr  out  32  word-aligned byte address
- mem_req_rdata  in  32  read data
- dict1_write_enable  out  1  append `dict1_write_val` to dict1 (likewise for dict2 and dict3)
- dict1_write_val  out  FIELD1_VAL_WIDTH (likewise dict2 and dict3 at their own value widths)

## Operation
- Image layout, starting at IMAGE_BASE:
  - Header word: cnt1 = [9:0], cnt2 = [19:10], cnt3 = [29:20]; bits [31:30] are ignored.
  - Then cnt1 dict1 entries, cnt2 dict2 entries and cnt3 dict3 entries, one word each at consecutive word addresses.
  - The low VAL_WIDTH bits of each entry word are used; the upper bits are ignored.
- States: IDLE, HDR, LOAD1, LOAD2, LOAD3, CHK (only with the macro defined), FIN.
- IDLE:
  - An accepted start clears `error`, sets `busy`, loads the address register with IMAGE_BASE and enters HDR.
  - Start is ignored in every state other than IDLE.
- HDR:
  - Capture the header.
  - If any cntN is greater than 2^FIELDN_KEY_WIDTH, set `error` and go to FIN. No dictionary write is issued.
  - Otherwise go to the first LOADn with a nonzero count. If all counts are zero, go to FIN (or CHK when the macro is defined).
- LOADn:
  - Each accepted word produces exactly one dictN write.
  - A per-state counter decrements once per accepted word. When it reaches 0, move to the next nonzero LOADn, then CHK or FIN.
- FIN: pulse `done`, clear `busy`, return to IDLE.
- Address: a 32-bit register advancing by 4 per accepted word. It wraps modulo 2^32 with no special handling.

## Timing
- Reset value of every output is 0: busy, done, error, mem_req_valid, mem_req_addr, all dictN_write_enable and all dictN_write_val.
- Reset asserted mid-load aborts immediately, issues no further writes and returns to IDLE. Dictionaries share `resetn`, so they are cleared as well.
- Read handshake:
  - `mem_req_valid` is registered and rises the cycle after a request-issuing state is entered.
  - It is held, with `mem_req_addr` stable, until the cycle in which `mem_req_ready` is 1. Data is captured in that cycle.
  - `mem_req_valid` drops for the following cycle and re-asserts the cycle after that if more words remain.
  - Back-to-back words therefore cost at least 2 cycles each.
- Dictionary writes:
  - `dictN_write_enable` is high for exactly one cycle: the cycle after the ready cycle.
  - `dictN_write_val` holds the captured value during that cycle.
  - At most one dictionary is written per cycle.
- `done` asserts the cycle after the last capture, or after the HDR error decision. `busy` falls in the same cycle that `done` rises.
- Latency with zero-wait memory is 2 × (1 + cnt1 + cnt2 + cnt3) + 1 cycles from start to done.

## Configuration
- DICT_LOADER_CHECKSUM_EN defined:
  - One extra word follows the last entry.
  - CHK reads it and compares it with the XOR of all full 32-bit entry words; the header is excluded.
  - A mismatch sets `error`. The writes already issued are not undone.
- Not defined: the CHK state and the checksum register are absent, and the load ends after the last entry.

## Structure
- Shared package holds:
  - the state enum;
  - the header field offsets (0, 10, 20) and the count width of 10;
  - the IMAGE_BASE default.
- The same field-width parameters are also used by the controller.
- Single module; no sub-module is needed. The three LOADn paths share one counter and one capture register.

## Test plan
- Header cnt1=2, cnt2=1, cnt3=3 with zero-wait memory -> 7 reads from 0xF000 to 0xF018; writes occur in order d1, d1, d2, d3, d3, d3 with the low-bit values; `done` arrives at cycle 15; `error`=0.
- cnt1=9, which exceeds 8 -> no dict writes, `error`=1, `done` pulses after the header read.
- Header all zero -> exactly one read, `done`, no writes; start pulsed while `busy` is ignored.
- Ready stalled 5 cycles on every word -> `mem_req_addr` is stable throughout the stall, each write still lasts 1 cycle, and the write count is unchanged.
- `resetn` pulled low after the 3rd write -> all outputs go to 0 the same cycle; a fresh start reloads from 0xF000.
- With DICT_LOADER_CHECKSUM_EN, entries 0x11 and 0x22 followed by checksum 0x33 -> `error`=0; checksum 0x34 -> `error`=1, and both writes have still occurred.
